// File: rtl/act_scheduler_if.sv
// act_scheduler_if: handshake and bus bundle around the activation scheduler.
// Carries the compute input stream, the result stream, the LUT-programming
// stream and the side facing the activation-function unit.
// master: the surrounding system (stream sources/sinks and the unit).
// slave:  the scheduler itself.
interface act_scheduler_if #(
    parameter int unsigned Q_SIZE    = 16,
    parameter int unsigned MASK_SIZE = 4,
    parameter int unsigned LUT_DEPTH = 6,
    parameter int unsigned LUT_SIZE  = 32
);
    // Compute input stream
    logic                           in_valid;
    logic                           in_ready;
    logic [Q_SIZE-1:0]              in_x;
    logic [MASK_SIZE-1:0]           in_mask;

    // Result stream
    logic                           out_valid;
    logic                           out_ready;
    logic [Q_SIZE-1:0]              out_fx;

    // LUT-programming stream
    logic                           cfg_valid;
    logic                           cfg_ready;
    logic [MASK_SIZE+LUT_DEPTH-1:0] cfg_addr;
    logic [LUT_SIZE-1:0]            cfg_data;
    logic                           cfg_last;

    // Activation-function unit side
    logic [Q_SIZE-1:0]              act_x;
    logic [MASK_SIZE-1:0]           act_mask;
    logic [Q_SIZE-1:0]              act_fx;
    logic                           act_we;
    logic [MASK_SIZE+LUT_DEPTH-1:0] act_waddr;
    logic [LUT_SIZE-1:0]            act_wdata;

    modport master (
        output in_valid, in_x, in_mask,
        input  in_ready,
        input  out_valid, out_fx,
        output out_ready,
        output cfg_valid, cfg_addr, cfg_data, cfg_last,
        input  cfg_ready,
        input  act_x, act_mask, act_we, act_waddr, act_wdata,
        output act_fx
    );

    modport slave (
        input  in_valid, in_x, in_mask,
        output in_ready,
        output out_valid, out_fx,
        input  out_ready,
        input  cfg_valid, cfg_addr, cfg_data, cfg_last,
        output cfg_ready,
        output act_x, act_mask, act_we, act_waddr, act_wdata,
        input  act_fx
    );

endinterface

// File: rtl/act_scheduler.sv
// act_scheduler: sequencing controller for the activation-function unit.
//
// Issues one accumulator beat per cycle to the unit, captures the unit result
// one cycle later and buffers it in a credit-checked result FIFO. A mask change
// inserts one bubble because the unit selects its function with the mask of
// the cycle after issue. LUT-programming bursts pre-empt compute traffic: the
// pipeline is drained first, so table writes never overlap in-flight reads.
//
// Optional feature macro: ACT_SCHED_STATS_EN builds the beat/stall counters;
// without it stat_beats and stat_stalls are tied to zero.
module act_scheduler #(
    parameter int unsigned Q_SIZE    = 16,
    parameter int unsigned MASK_SIZE = 4,
    parameter int unsigned LUT_DEPTH = 6,
    parameter int unsigned LUT_SIZE  = 32,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    act_scheduler_if.slave     bus,
    output logic               busy,
    output logic [31:0]        stat_beats,
    output logic [31:0]        stat_stalls
);

    localparam int unsigned ADDR_W = MASK_SIZE + LUT_DEPTH;
    localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StLoad,
        StGuard
    } state_e;

    state_e                 state_q;

    // Issue stage (drives the unit) and capture stage (unit result valid)
    logic                   iss_valid_q;
    logic                   cap_valid_q;
    logic [Q_SIZE-1:0]      act_x_q;
    logic [MASK_SIZE-1:0]   act_mask_q;

    // LUT write port
    logic                   act_we_q;
    logic [ADDR_W-1:0]      act_waddr_q;
    logic [LUT_SIZE-1:0]    act_wdata_q;

    // Result FIFO
    logic [Q_SIZE-1:0]      fifo_mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       fifo_count_q;

    logic [1:0]             inflight;
    logic [CNT_W:0]         credit_used;
    logic                   credit_ok;
    logic                   mask_conflict;
    logic                   in_ready;
    logic                   in_fire;
    logic                   cfg_fire;
    logic                   push;
    logic                   pop;
    logic                   out_valid;

    assign inflight    = {1'b0, iss_valid_q} + {1'b0, cap_valid_q};
    // Credits count beats already in the FIFO plus beats still in the pipe,
    // so an accepted beat always has a slot waiting for it.
    assign credit_used = {1'b0, fifo_count_q} + {{(CNT_W - 1){1'b0}}, inflight};
    assign credit_ok   = credit_used < (CNT_W + 1)'(OUT_DEPTH);

    // The unit needs the issue-cycle mask held one more cycle.
    assign mask_conflict = iss_valid_q && (bus.in_mask != act_mask_q);

    // cfg_valid wins over a simultaneous in_valid; reset gating keeps the
    // handshake closed while rst_n is low.
    assign in_ready = rst_n && (state_q == StRun) && !bus.cfg_valid && credit_ok
                      && !mask_conflict;
    assign in_fire  = bus.in_valid && in_ready;
    assign cfg_fire = bus.cfg_valid && (state_q == StLoad);

    assign out_valid = (fifo_count_q != '0);
    assign push      = cap_valid_q;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.cfg_ready = (state_q == StLoad);
    assign bus.out_valid = out_valid;
    assign bus.out_fx    = fifo_mem_q[rd_ptr_q];
    assign bus.act_x     = act_x_q;
    assign bus.act_mask  = act_mask_q;
    assign bus.act_we    = act_we_q;
    assign bus.act_waddr = act_waddr_q;
    assign bus.act_wdata = act_wdata_q;

    assign busy = (state_q == StDrain) || (state_q == StLoad);

    // Issue/capture pipeline; act_x/act_mask only change on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            cap_valid_q <= 1'b0;
            act_x_q     <= '0;
            act_mask_q  <= '0;
        end else begin
            iss_valid_q <= in_fire;
            cap_valid_q <= iss_valid_q;
            if (in_fire) begin
                act_x_q    <= bus.in_x;
                act_mask_q <= bus.in_mask;
            end
        end
    end

    // Result FIFO: captured unit output is pushed, head pops on out handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= bus.act_fx;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Arbitration FSM with registered LUT write strobe/address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            act_we_q    <= 1'b0;
            act_waddr_q <= '0;
            act_wdata_q <= '0;
        end else begin
            act_we_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (bus.cfg_valid) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (inflight == 2'd0) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (cfg_fire) begin
                        act_we_q    <= 1'b1;
                        act_waddr_q <= bus.cfg_addr;
                        act_wdata_q <= bus.cfg_data;
                        if (bus.cfg_last) begin
                            state_q <= StGuard;
                        end
                    end
                end
                StGuard: begin
                    // Last write lands during this cycle; no reads yet.
                    state_q <= StRun;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

`ifdef ACT_SCHED_STATS_EN
    logic [31:0] beats_q;
    logic [31:0] stalls_q;

    // Output handshakes and input stall cycles; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (pop) begin
                beats_q <= beats_q + 32'd1;
            end
            if (bus.in_valid && !in_ready) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_beats  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_act_scheduler.sv
// tb_act_scheduler: directed bench for act_scheduler with a behavioural
// activation unit (one-cycle registered x, function chosen by live mask).
module tb_act_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] stat_beats;
    logic [31:0] stat_stalls;

    act_scheduler_if bus_if ();

    act_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if.slave),
        .busy        (busy),
        .stat_beats  (stat_beats),
        .stat_stalls (stat_stalls)
    );

    always #5 clk = ~clk;

    // Behavioural unit: x registered once, function picked by mask[3:2].
    logic [15:0] unit_x;

    function automatic logic [15:0] unit_fn(input logic [15:0] x, input logic [3:0] m);
        case (m[3:2])
            2'b00:   unit_fn = x ^ 16'h00FF;
            2'b01:   unit_fn = x;
            2'b10:   unit_fn = x[15] ? 16'h0000 : 16'h0100;
            default: unit_fn = x[15] ? 16'h0000 : x;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) unit_x <= 16'h0000;
        else        unit_x <= bus_if.act_x;
    end

    assign bus_if.act_fx = unit_fn(unit_x, bus_if.act_mask);

    // Monitor: records handshake and write events with their cycle numbers.
    int          cyc = 0;
    int          acc_q[$];
    logic [15:0] out_q[$];
    int          oc_q[$];
    int          we_c[$];
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic        wb_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus_if.in_valid && bus_if.in_ready) acc_q.push_back(cyc);
            if (bus_if.out_valid && bus_if.out_ready) begin
                out_q.push_back(bus_if.out_fx);
                oc_q.push_back(cyc);
            end
            if (bus_if.act_we) begin
                we_c.push_back(cyc);
                wa_q.push_back(bus_if.act_waddr);
                wd_q.push_back(bus_if.act_wdata);
                wb_q.push_back(busy);
            end
        end
        cyc = cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        acc_q.delete();
        out_q.delete();
        oc_q.delete();
        we_c.delete();
        wa_q.delete();
        wd_q.delete();
        wb_q.delete();
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send_beat(input logic [15:0] x, input logic [3:0] m);
        logic done;
        done            = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_x     = x;
        bus_if.in_mask  = m;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = bus_if.in_ready;
            tick();
        end
        check("send_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic send_cfg(input logic [9:0] a, input logic [31:0] d, input logic l);
        logic done;
        done             = 1'b0;
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_addr  = a;
        bus_if.cfg_data  = d;
        bus_if.cfg_last  = l;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = bus_if.cfg_ready;
            tick();
        end
        check("cfg_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_outputs(input int n, input string tag);
        for (int t = 0; t < 100 && out_q.size() < n; t++) tick();
        check(tag, out_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic a;

        bus_if.in_valid  = 1'b0;
        bus_if.in_x      = 16'h0000;
        bus_if.in_mask   = 4'h0;
        bus_if.out_ready = 1'b0;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_addr  = 10'h000;
        bus_if.cfg_data  = 32'h0;
        bus_if.cfg_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, bus_if.in_ready}, 32'd0);
        check("rst_cfg_ready", {31'd0, bus_if.cfg_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_out_fx",    {16'd0, bus_if.out_fx}, 32'd0);
        check("rst_act_x",     {16'd0, bus_if.act_x}, 32'd0);
        check("rst_act_mask",  {28'd0, bus_if.act_mask}, 32'd0);
        check("rst_act_we",    {31'd0, bus_if.act_we}, 32'd0);
        check("rst_act_waddr", {22'd0, bus_if.act_waddr}, 32'd0);
        check("rst_act_wdata", bus_if.act_wdata, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_beats",     stat_beats, 32'd0);
        check("rst_stalls",    stat_stalls, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back ID beats, constant mask
        bus_if.out_ready = 1'b1;
        clear_queues();
        for (int i = 0; i < 4; i++) send_beat(16'h0100 + 16'(i), 4'h4);
        bus_if.in_valid = 1'b0;
        wait_outputs(4, "t1_count");
        for (int i = 0; i < 4; i++) check("t1_data", {16'd0, out_q[i]}, 32'h0100 + 32'(i));
        check("t1_latency", oc_q[0] - acc_q[0], 32'd3);
        check("t1_accept_rate", acc_q[3] - acc_q[0], 32'd3);
        check("t1_output_rate", oc_q[3] - oc_q[0], 32'd3);

        // Alternating ID/RELU masks: one bubble per change
        clear_queues();
        send_beat(16'hFF00, 4'h4);
        send_beat(16'hFF00, 4'hC);
        send_beat(16'hFF00, 4'h4);
        send_beat(16'hFF00, 4'hC);
        bus_if.in_valid = 1'b0;
        wait_outputs(4, "t2_count");
        check("t2_data0", {16'd0, out_q[0]}, 32'hFF00);
        check("t2_data1", {16'd0, out_q[1]}, 32'h0000);
        check("t2_data2", {16'd0, out_q[2]}, 32'hFF00);
        check("t2_data3", {16'd0, out_q[3]}, 32'h0000);
        for (int i = 1; i < 4; i++) check("t2_bubble", acc_q[i] - acc_q[i-1], 32'd2);
`ifdef ACT_SCHED_STATS_EN
        check("t2_stat_beats",  stat_beats, 32'd8);
        check("t2_stat_stalls", stat_stalls, 32'd3);
`else
        check("t2_stat_beats",  stat_beats, 32'd0);
        check("t2_stat_stalls", stat_stalls, 32'd0);
`endif

        // Back-pressure: credits admit exactly OUT_DEPTH beats
        bus_if.out_ready = 1'b0;
        clear_queues();
        n               = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_mask  = 4'h4;
        bus_if.in_x     = 16'h2000;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            a = bus_if.in_ready;
            tick();
            if (a) begin
                n++;
                bus_if.in_x = 16'h2000 + 16'(n);
            end
        end
        check("t3_accepted", n, 32'd4);
        @(negedge clk);
        check("t3_in_ready",  {31'd0, bus_if.in_ready}, 32'd0);
        check("t3_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("t3_head_hold", {16'd0, bus_if.out_fx}, 32'h2000);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        wait_outputs(4, "t3_count");
        for (int i = 0; i < 4; i++) check("t3_data", {16'd0, out_q[i]}, 32'h2000 + 32'(i));

        // LUT burst during streaming
        clear_queues();
        send_beat(16'h3000, 4'h4);
        send_beat(16'h3001, 4'h4);
        bus_if.in_x      = 16'h3002;
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_addr  = 10'h000;
        bus_if.cfg_data  = 32'hDEAD0000;
        bus_if.cfg_last  = 1'b0;
        @(negedge clk);
        check("t4_cfg_priority", {31'd0, bus_if.in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) send_cfg(10'(i), 32'hDEAD0000 + 32'(i), (i == 3));
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_last  = 1'b0;
        for (int i = 2; i < 6; i++) send_beat(16'h3000 + 16'(i), 4'h4);
        bus_if.in_valid = 1'b0;
        wait_outputs(6, "t4_count");
        for (int i = 0; i < 6; i++) check("t4_data", {16'd0, out_q[i]}, 32'h3000 + 32'(i));
        check("t4_we_count", we_c.size(), 32'd4);
        if (we_c.size() == 4) begin
            check("t4_drain_wait", we_c[0] - acc_q[1], 32'd5);
            check("t4_we_span", we_c[3] - we_c[0], 32'd3);
            for (int i = 0; i < 4; i++) begin
                check("t4_waddr", {22'd0, wa_q[i]}, 32'(i));
                check("t4_wdata", wd_q[i], 32'hDEAD0000 + 32'(i));
            end
            check("t4_busy_load", {31'd0, wb_q[0]}, 32'd1);
            check("t4_busy_guard", {31'd0, wb_q[3]}, 32'd0);
            check("t4_guard_gap", acc_q[2] - we_c[3], 32'd1);
        end
        check("t4_we_idle", {31'd0, bus_if.act_we}, 32'd0);

        // Reset with beats in flight and in the FIFO
        bus_if.out_ready = 1'b0;
        clear_queues();
        n               = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_mask  = 4'h4;
        bus_if.in_x     = 16'h4000;
        for (int t = 0; t < 20 && n < 4; t++) begin
            @(negedge clk);
            a = bus_if.in_ready;
            tick();
            if (a) begin
                n++;
                bus_if.in_x = 16'h4000 + 16'(n);
            end
        end
        check("t5_filled", n, 32'd4);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("t5_rst_in_ready",  {31'd0, bus_if.in_ready}, 32'd0);
        check("t5_rst_out_fx",    {16'd0, bus_if.out_fx}, 32'd0);
        check("t5_rst_act_x",     {16'd0, bus_if.act_x}, 32'd0);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset while a LUT write is pending
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_addr  = 10'h03F;
        bus_if.cfg_data  = 32'h12345678;
        bus_if.cfg_last  = 1'b0;
        for (int t = 0; t < 20 && !bus_if.act_we; t++) tick();
        check("t5_we_seen", {31'd0, bus_if.act_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_act_we",    {31'd0, bus_if.act_we}, 32'd0);
        check("t5_rst_act_waddr", {22'd0, bus_if.act_waddr}, 32'd0);
        check("t5_rst_cfg_ready", {31'd0, bus_if.cfg_ready}, 32'd0);
        check("t5_rst_busy",      {31'd0, busy}, 32'd0);
        bus_if.cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First beat after reset is the first output
        bus_if.out_ready = 1'b1;
        clear_queues();
        send_beat(16'h5000, 4'h4);
        bus_if.in_valid = 1'b0;
        wait_outputs(1, "t5_post_count");
        repeat (5) tick();
        check("t5_post_only", out_q.size(), 32'd1);
        check("t5_post_data", {16'd0, out_q[0]}, 32'h5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
